// File: rtl/twos_to_signmag_serial_if.sv
// ---------------------------------------------------------------------------
// twos_to_signmag_serial_if
//   Handshake bundle for the bit-serial two's-complement to sign-magnitude
//   decoder.
//
//   Input side : in_valid, in_ready, in_data[WIDTH-1:0]
//   Output side: out_valid, out_ready, out_sign, out_mag[WIDTH-2:0], out_ovf
//
//   master : the surrounding logic (drives words in, consumes results)
//   slave  : the decoder itself
// ---------------------------------------------------------------------------
interface twos_to_signmag_serial_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_sign;
   logic [WIDTH-2:0] out_mag;
   logic             out_ovf;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_sign, out_mag, out_ovf
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_sign, out_mag, out_ovf
   );
endinterface

// File: rtl/twos_to_signmag_serial.sv
// ---------------------------------------------------------------------------
// twos_to_signmag_serial
//   Bit-serial decoder from a WIDTH-bit two's-complement word to
//   sign-magnitude, one bit per clock, LSB first. Holds one word in flight.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    twos_to_signmag_serial_if.slave
//              in_valid/in_ready/in_data         word input handshake
//              out_valid/out_ready               result handshake
//              out_sign/out_mag/out_ovf          registered result
//
//   Optional feature macro: TWOS_DEC_SAT_EN
//     defined   : the -2^(WIDTH-1) input reports an all-ones magnitude
//     undefined : that input reports a zero (wrapped) magnitude
//     out_ovf and out_sign are 1 for that input either way.
//
//   Timing: accept on edge E0, WIDTH shift edges E1..EWIDTH, results are
//   registered on edge EWIDTH+1 when out_valid rises.
// ---------------------------------------------------------------------------
module twos_to_signmag_serial #(
   parameter int WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   twos_to_signmag_serial_if.slave       bus
);

   localparam int                 CNT_W = $clog2(WIDTH + 1);
   // Counter value on the edge that transfers the finished result out.
   localparam logic [CNT_W-1:0]   LAST  = CNT_W'(WIDTH);

`ifdef TWOS_DEC_SAT_EN
   localparam logic [WIDTH-2:0]   OVF_MAG = '1;
`else
   localparam logic [WIDTH-2:0]   OVF_MAG = '0;
`endif

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                  state;
   logic [CNT_W-1:0]        cnt;
   logic                    in_ready_r;
   logic                    out_valid_r;
   logic                    out_sign_r;
   logic [WIDTH-2:0]        out_mag_r;
   logic                    out_ovf_r;

   logic signed [WIDTH-1:0] word_p0;     // word being consumed, LSB at bit 0
   logic [WIDTH-1:0]        result_p1;   // magnitude assembled MSB end first
   logic                    sign_p0;
   logic                    seen_one_p0;
   logic                    obit;
   logic                    accept;
   logic                    shifting;

   // Only -2^(WIDTH-1) sets the top result bit, and then the lower bits are
   // already zero, so the wrapped case falls out of the same expression.
   function automatic logic [WIDTH-2:0] present_mag(input logic [WIDTH-1:0] res);
      return res[WIDTH-1] ? OVF_MAG : res[WIDTH-2:0];
   endfunction

   assign accept   = in_ready_r && bus.in_valid;
   assign shifting = (state == SHIFT) && (cnt != LAST);

   // Copy bits through up to and including the first 1, invert afterwards.
   always_comb begin
      obit = word_p0[0];
      if (sign_p0 && seen_one_p0) begin
         obit = ~word_p0[0];
      end
   end

   // ---- stage p0 -> p1: serial negate datapath (no reset; reloaded on accept)
   always_ff @(posedge clk) begin
      if (accept) begin
         word_p0     <= bus.in_data;
         sign_p0     <= bus.in_data[WIDTH-1];
         seen_one_p0 <= 1'b0;
      end else if (shifting) begin
         word_p0     <= word_p0 >>> 1;
         seen_one_p0 <= seen_one_p0 | word_p0[0];
         result_p1   <= {obit, result_p1[WIDTH-1:1]};
      end
   end

   // ---- control FSM and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         out_sign_r  <= 1'b0;
         out_mag_r   <= '0;
         out_ovf_r   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state      <= SHIFT;
                  cnt        <= '0;
                  in_ready_r <= 1'b0;
               end
            end
            SHIFT: begin
               if (cnt == LAST) begin
                  state       <= DONE;
                  out_valid_r <= 1'b1;
                  out_sign_r  <= sign_p0;
                  out_mag_r   <= present_mag(result_p1);
                  out_ovf_r   <= result_p1[WIDTH-1];
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_sign  = out_sign_r;
   assign bus.out_mag   = out_mag_r;
   assign bus.out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_twos_to_signmag_serial.sv
// ---------------------------------------------------------------------------
// tb_twos_to_signmag_serial
//   Bench for twos_to_signmag_serial at WIDTH=8. A vector table and a few
//   hand-written sequences feed a scoreboard; expected results are queued on
//   each accepted word and compared when the result handshake occurs.
//   Honours TWOS_DEC_SAT_EN for the -128 expectation.
// ---------------------------------------------------------------------------
module tb_twos_to_signmag_serial;

   localparam int WIDTH = 8;

`ifdef TWOS_DEC_SAT_EN
   localparam logic [6:0] OVF_MAG = 7'h7F;
`else
   localparam logic [6:0] OVF_MAG = 7'h00;
`endif

   typedef struct packed {
      logic       s;
      logic [6:0] m;
      logic       o;
   } exp_t;

   typedef struct {
      logic [7:0] din;
      exp_t       e;
   } vec_t;

   logic clk;
   logic rst_n;
   int   cycle;
   int   tests;
   int   fails;
   int   acc_cnt;
   int   acc_last;
   int   acc_prev;
   exp_t cur_exp;
   exp_t sb[$];
   int   acc_q[$];
   vec_t vecs[9];

   twos_to_signmag_serial_if #(.WIDTH(WIDTH)) bus ();

   twos_to_signmag_serial #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cycle);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      fails++;
      $display("FAIL %s: event did not occur within its bound (cycle %0d)", name, cycle);
   endtask

   // Independent reference: absolute value through integer arithmetic.
   function automatic exp_t model(input logic [7:0] x);
      exp_t e;
      int   v;
      v   = int'($signed(x));
      e.s = x[7];
      if (v < 0) v = -v;
      e.o = (v == 128);
      e.m = e.o ? OVF_MAG : 7'(v);
      return e;
   endfunction

   // Observes both handshakes on the falling edge, ahead of the edge that acts.
   task automatic monitor();
      logic prev_valid;
      logic hs_prev;
      exp_t e;
      int   lat;
      prev_valid = 1'b0;
      hs_prev    = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_valid = 1'b0;
            hs_prev    = 1'b0;
         end else begin
            if (hs_prev) begin
               check("in_ready_after_handshake", int'(bus.in_ready), 1);
               check("out_valid_after_handshake", int'(bus.out_valid), 0);
            end
            hs_prev = 1'b0;
            if (bus.in_valid && bus.in_ready) begin
               sb.push_back(cur_exp);
               acc_q.push_back(cycle + 1);
               acc_prev = acc_last;
               acc_last = cycle + 1;
               acc_cnt++;
            end
            if (bus.out_valid && !prev_valid) begin
               if (acc_q.size() == 0) begin
                  fail_now("latency_no_accept");
               end else begin
                  lat = cycle - acc_q.pop_front();
                  check("latency", lat, WIDTH + 1);
               end
            end
            if (bus.out_valid && bus.out_ready) begin
               if (sb.size() == 0) begin
                  fail_now("unexpected_output");
               end else begin
                  e = sb.pop_front();
                  check("out_sign", int'(bus.out_sign), int'(e.s));
                  check("out_mag", int'(bus.out_mag), int'(e.m));
                  check("out_ovf", int'(bus.out_ovf), int'(e.o));
               end
               hs_prev = 1'b1;
            end
            prev_valid = bus.out_valid;
         end
      end
   endtask

   task automatic send(input logic [7:0] d, input exp_t e);
      int start;
      int n;
      start       = acc_cnt;
      n           = 0;
      cur_exp     = e;
      bus.in_data = d;
      bus.in_valid = 1'b1;
      while (acc_cnt == start && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (acc_cnt == start) fail_now("accept_timeout");
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(sb.size() == 0 && bus.in_ready && !bus.out_valid) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) fail_now("idle_timeout");
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_in_ready"},  int'(bus.in_ready), 1);
      check({tag, "_out_valid"}, int'(bus.out_valid), 0);
      check({tag, "_out_sign"},  int'(bus.out_sign), 0);
      check({tag, "_out_mag"},   int'(bus.out_mag), 0);
      check({tag, "_out_ovf"},   int'(bus.out_ovf), 0);
   endtask

   initial begin
      int   n;
      int   start;
      logic [7:0] x;

      tests = 0; fails = 0; acc_cnt = 0; acc_last = 0; acc_prev = 0;
      cur_exp = '0;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.out_ready = 1'b1;

      vecs[0] = '{8'hFB, '{1'b1, 7'h05, 1'b0}};
      vecs[1] = '{8'h05, '{1'b0, 7'h05, 1'b0}};
      vecs[2] = '{8'hFF, '{1'b1, 7'h01, 1'b0}};
      vecs[3] = '{8'h80, '{1'b1, OVF_MAG, 1'b1}};
      vecs[4] = '{8'h7F, '{1'b0, 7'h7F, 1'b0}};
      vecs[5] = '{8'h00, '{1'b0, 7'h00, 1'b0}};
      vecs[6] = '{8'h81, '{1'b1, 7'h7F, 1'b0}};
      vecs[7] = '{8'h01, '{1'b0, 7'h01, 1'b0}};
      vecs[8] = '{8'h9C, '{1'b1, 7'h64, 1'b0}};

      fork
         monitor();
      join_none

      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Table vectors, out_ready held high.
      for (int i = 0; i < 9; i++) begin
         send(vecs[i].din, vecs[i].e);
         wait_idle();
      end

      // Back to back: in_valid stays high across both words.
      bus.in_data  = 8'h05;
      cur_exp      = '{1'b0, 7'h05, 1'b0};
      bus.in_valid = 1'b1;
      start = acc_cnt;
      n = 0;
      while (acc_cnt == start && n < 100) begin @(posedge clk); #1; n++; end
      if (acc_cnt == start) fail_now("b2b_first_accept");
      bus.in_data = 8'hFF;
      cur_exp     = '{1'b1, 7'h01, 1'b0};
      start = acc_cnt;
      n = 0;
      while (acc_cnt == start && n < 100) begin @(posedge clk); #1; n++; end
      if (acc_cnt == start) fail_now("b2b_second_accept");
      bus.in_valid = 1'b0;
      check("b2b_accept_spacing", acc_last - acc_prev, WIDTH + 3);
      wait_idle();

      // Backpressure: result held while in_valid pulses with another word.
      bus.out_ready = 1'b0;
      send(8'hC8, '{1'b1, 7'h38, 1'b0});
      n = 0;
      while (!bus.out_valid && n < 50) begin @(posedge clk); #1; n++; end
      if (!bus.out_valid) fail_now("bp_out_valid");
      start = acc_cnt;
      cur_exp = '{1'b0, 7'h12, 1'b0};
      for (int k = 0; k < 5; k++) begin
         bus.in_data  = 8'h12;
         bus.in_valid = (k % 2 == 0);
         @(posedge clk); #1;
         check("bp_out_valid_held", int'(bus.out_valid), 1);
         check("bp_in_ready_low",   int'(bus.in_ready), 0);
         check("bp_sign_frozen",    int'(bus.out_sign), 1);
         check("bp_mag_frozen",     int'(bus.out_mag), 'h38);
         check("bp_ovf_frozen",     int'(bus.out_ovf), 0);
      end
      check("bp_no_accept", acc_cnt - start, 0);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      n = 0;
      while (acc_cnt == start && n < 100) begin @(posedge clk); #1; n++; end
      if (acc_cnt == start) fail_now("bp_second_accept");
      bus.in_valid = 1'b0;
      wait_idle();

      // Reset on the third SHIFT cycle of 0x9C.
      send(8'h9C, '{1'b1, 7'h64, 1'b0});
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_reset_values("midshift_reset");
      sb.delete();
      acc_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("no_partial_result", int'(bus.out_valid), 0);
      send(8'h9C, '{1'b1, 7'h64, 1'b0});
      wait_idle();

      // Random words against the arithmetic model.
      for (int r = 0; r < 12; r++) begin
         x = 8'($urandom);
         send(x, model(x));
         wait_idle();
      end

      repeat (3) @(posedge clk);
      #1;
      if (sb.size() != 0) fail_now("scoreboard_drain");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
